// File: rtl/masked_pkg.sv
// masked_pkg: shared definitions for the masked operand stage.
//   - default LFSR width and reset seed
//   - feedback tap positions of the 16-bit Fibonacci LFSR
//   - occupancy state of the single-entry share register
package masked_pkg;

  localparam int          LFSR_W_DEF = 16;
  localparam logic [15:0] SEED_DEF   = 16'hACE1;

  // Feedback taps: fb = l[0] ^ l[2] ^ l[3] ^ l[5]
  localparam int TAP_0 = 0;
  localparam int TAP_1 = 2;
  localparam int TAP_2 = 3;
  localparam int TAP_3 = 5;

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

endpackage

// File: rtl/mask_lfsr.sv
// mask_lfsr: Fibonacci LFSR (shift right) supplying mask bits.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset (state <= SEED)
//   step2        advance the register by two steps this cycle
//   load         replace the state with load_val (wins over step2)
//   load_val     reseed value; an all-zero value is replaced by SEED
//   state        current LFSR state
module mask_lfsr
  import masked_pkg::*;
#(
  parameter int                LFSR_W = LFSR_W_DEF,
  parameter logic [LFSR_W-1:0] SEED   = SEED_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              step2,
  input  logic              load,
  input  logic [LFSR_W-1:0] load_val,
  output logic [LFSR_W-1:0] state
);

  logic [LFSR_W-1:0] state_r;
  logic [LFSR_W-1:0] state_next_s;

  // One shift: feedback bit enters at the top, bit 0 leaves.
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] l);
    logic fb;
    fb = l[TAP_0] ^ l[TAP_1] ^ l[TAP_2] ^ l[TAP_3];
    return {fb, l[LFSR_W-1:1]};
  endfunction

  // Next-state selection: reload (zero guarded), double step, or hold.
  always_comb begin
    state_next_s = state_r;
    if (load) begin
      // An all-zero state would lock the LFSR, so fall back to SEED.
      if (load_val == {LFSR_W{1'b0}}) begin
        state_next_s = SEED;
      end else begin
        state_next_s = load_val;
      end
    end else if (step2) begin
      state_next_s = lfsr_step(lfsr_step(state_r));
    end else begin
      state_next_s = state_r;
    end
  end

  // LFSR state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= SEED;
    end else begin
      state_r <= state_next_s;
    end
  end

  assign state = state_r;

endmodule

// File: rtl/masked_share_gen.sv
// masked_share_gen: splits unmasked operand bits a, b into two-share pairs
// (x1 = fresh mask, x0 = x ^ x1) for the downstream masked AND gate.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   seed_load, seed_data  reseed the mask LFSR (blocks accept that cycle)
//   in_valid, in_ready    operand handshake; in_a, in_b operands
//   out_valid, out_ready  share handshake; a0, a1, b0, b1 registered shares
// Optional feature: define MASKGEN_REFRESH_EN to re-randomize held shares
// on every stalled cycle (share XORs preserved).
module masked_share_gen
  import masked_pkg::*;
#(
  parameter int                LFSR_W = LFSR_W_DEF,
  parameter logic [LFSR_W-1:0] SEED   = SEED_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_a,
  input  logic              in_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              a0,
  output logic              a1,
  output logic              b0,
  output logic              b1
);

  state_t            state_r;
  state_t            state_next_s;
  logic [LFSR_W-1:0] lfsr_s;
  logic [LFSR_W-3:0] lfsr_unused_s;
  logic              accept_s;
  logic              refresh_s;
  logic              step2_s;
  logic              mask_a_s;
  logic              mask_b_s;
  logic              a0_r, a1_r, b0_r, b1_r;

  assign mask_a_s      = lfsr_s[0];
  assign mask_b_s      = lfsr_s[1];
  assign lfsr_unused_s = lfsr_s[LFSR_W-1:2];

  assign out_valid = (state_r == FULL);
  // Single-entry register without skid: ready follows out_ready directly.
  assign in_ready  = rst_n && !seed_load && (!out_valid || out_ready);
  assign accept_s  = in_valid && in_ready;

`ifdef MASKGEN_REFRESH_EN
  assign refresh_s = out_valid && !out_ready && !seed_load;
`else
  assign refresh_s = 1'b0;
`endif

  // accept_s already excludes seed_load; refresh_s excludes it explicitly.
  assign step2_s = accept_s || refresh_s;

  mask_lfsr #(
    .LFSR_W (LFSR_W),
    .SEED   (SEED)
  ) u_lfsr (
    .clk      (clk),
    .rst_n    (rst_n),
    .step2    (step2_s),
    .load     (seed_load),
    .load_val (seed_data),
    .state    (lfsr_s)
  );

  // Occupancy next-state: fill on accept, empty on drain without refill.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      EMPTY: begin
        if (accept_s) begin
          state_next_s = FULL;
        end else begin
          state_next_s = EMPTY;
        end
      end
      FULL: begin
        if (out_ready && !accept_s) begin
          state_next_s = EMPTY;
        end else begin
          state_next_s = FULL;
        end
      end
      default: state_next_s = EMPTY;
    endcase
  end

  // Occupancy state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= EMPTY;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Share registers: operands are masked before capture, never stored bare.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a0_r <= 1'b0;
      a1_r <= 1'b0;
      b0_r <= 1'b0;
      b1_r <= 1'b0;
    end else if (accept_s) begin
      a1_r <= mask_a_s;
      a0_r <= in_a ^ mask_a_s;
      b1_r <= mask_b_s;
      b0_r <= in_b ^ mask_b_s;
    end else if (refresh_s) begin
      // Same fresh bit into both shares keeps x0 ^ x1 unchanged.
      a1_r <= a1_r ^ mask_a_s;
      a0_r <= a0_r ^ mask_a_s;
      b1_r <= b1_r ^ mask_b_s;
      b0_r <= b0_r ^ mask_b_s;
    end else begin
      a0_r <= a0_r;
      a1_r <= a1_r;
      b0_r <= b0_r;
      b1_r <= b1_r;
    end
  end

  assign a0 = a0_r;
  assign a1 = a1_r;
  assign b0 = b0_r;
  assign b1 = b1_r;

endmodule
